oscill_capture_writer: RTL and testbench

OSCILL_CAPTURE_WRITER -- requirements
Module: oscill_capture_writer

---
 rtl/oscill_capture_writer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_oscill_capture_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oscill_capture_writer.sv
// Oscilloscope capture writer: packs ADC sample pairs into words and
// streams them through a small FIFO to an Avalon-MM circular buffer.
module oscill_capture_writer #(
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 80000,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       adc_data,
  input  logic              adc_valid,
  input  logic [15:0]       trig_level,
  input  logic              trig_rising,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [ADDR_W-1:0] post_len,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_word,
  output logic              overflow
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FIFO_D - 1);
  localparam logic [CW-1:0] F_FULL = CW'(FIFO_D);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [15:0] level_q, level_d;
  logic        rising_q, rising_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] post_q, post_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic        half_q, half_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] prev_q, prev_d;
  logic        prev_v_q, prev_v_d;
  logic        abort_q, abort_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;

  logic [31:0]       mem_d_q [FIFO_D];
  logic [ADDR_W-1:0] mem_a_q [FIFO_D];

  logic f_empty;
  logic f_full;
  logic pop;
  logic capt;
  logic abort_hit;
  logic start_hit;
  logic smp;
  logic word;
  logic push;
  logic hit;
  logic [ADDR_W-1:0] wptr_nx;

  function automatic logic [PW-1:0] p_inc(
    input logic [PW-1:0] p
  );
    return (p == P_LAST) ? '0 : p + PW'(1);
  endfunction

  assign f_empty   = (fcnt_q == '0);
  assign f_full    = (fcnt_q == F_FULL);
  assign pop       = !f_empty && !avm_waitrequest;
  assign capt      = (state_q == PRE) ||
                     (state_q == ARMED) ||
                     (state_q == POST);
  assign abort_hit = abort && capt;
  assign start_hit = start && (state_q == IDLE);
  assign smp       = capt && !abort_hit && adc_valid;
  assign word      = smp && half_q;
  assign push      = word && (!f_full || pop);
  assign wptr_nx   = (wptr_q == A_LAST) ? '0 : wptr_q + ADDR_W'(1);

  always_comb begin
    hit = 1'b0;
    if (state_q == ARMED && smp && prev_v_q) begin
      if (rising_q)
        hit = (prev_q < level_q) && (adc_data >= level_q);
      else
        hit = (prev_q > level_q) && (adc_data <= level_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    rising_d = rising_q;
    pre_d    = pre_q;
    post_d   = post_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    half_d   = half_q;
    lo_d     = lo_q;
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
    abort_d  = abort_q;
    done_d   = done_q;
    ovf_d    = ovf_q;

    if (start_hit) begin
      level_d  = trig_level;
      rising_d = trig_rising;
      pre_d    = pre_len;
      post_d   = post_len;
      wptr_d   = '0;
      cnt_d    = '0;
      half_d   = 1'b0;
      prev_v_d = 1'b0;
      abort_d  = 1'b0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      state_d  = PRE;
    end

    if (smp) begin
      prev_d   = adc_data;
      prev_v_d = 1'b1;
      half_d   = !half_q;
      if (!half_q) lo_d = adc_data;
    end

    // dropped words still consume an address slot
    if (word) begin
      wptr_d = wptr_nx;
      if (!push) ovf_d = 1'b1;
    end

    unique case (state_q)
      PRE: begin
        if (pre_q == '0) begin
          state_d = ARMED;
        end else if (word) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == pre_q - ADDR_W'(1)) begin
            cnt_d   = '0;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (hit) begin
          trig_d = wptr_q;
          if (!word) begin
            cnt_d   = '0;
            state_d = POST;
          end else if (post_q == '0) begin
            state_d = DRAIN;
          end else begin
            cnt_d   = ADDR_W'(1);
            state_d = POST;
          end
        end
      end
      POST: begin
        if (word) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == post_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (f_empty) begin
          state_d = IDLE;
          done_d  = !abort_q;
        end
      end
      default: ;
    endcase

    if (abort_hit) begin
      state_d = DRAIN;
      abort_d = 1'b1;
      half_d  = 1'b0;
    end
  end

  always_comb begin
    rd_d   = pop  ? p_inc(rd_q) : rd_q;
    wr_d   = push ? p_inc(wr_q) : wr_q;
    fcnt_d = fcnt_q;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    // on abort keep only a head that is stuck in a stalled write
    if (abort_hit) begin
      rd_d = rd_q;
      if (!f_empty && avm_waitrequest) begin
        fcnt_d = CW'(1);
        wr_d   = p_inc(rd_q);
      end else begin
        fcnt_d = '0;
        wr_d   = rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      level_q  <= '0;
      rising_q <= 1'b0;
      pre_q    <= '0;
      post_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      trig_q   <= '0;
      half_q   <= 1'b0;
      lo_q     <= '0;
      prev_q   <= '0;
      prev_v_q <= 1'b0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      rising_q <= rising_d;
      pre_q    <= pre_d;
      post_q   <= post_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      half_q   <= half_d;
      lo_q     <= lo_d;
      prev_q   <= prev_d;
      prev_v_q <= prev_v_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_D; i++) begin
        mem_d_q[i] <= '0;
        mem_a_q[i] <= '0;
      end
    end else if (push) begin
      mem_d_q[wr_q] <= {adc_data, lo_q};
      mem_a_q[wr_q] <= wptr_q;
    end
  end

  assign avm_write      = !f_empty;
  assign avm_address    = mem_a_q[rd_q];
  assign avm_writedata  = mem_d_q[rd_q];
  assign avm_byteenable = 4'hF;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign trig_word      = trig_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_oscill_capture_writer.sv
// Scoreboard bench for oscill_capture_writer on a shrunken buffer
// (DEPTH=20) so address wrap is reachable in a short run.
module tb_oscill_capture_writer;

  localparam int AW = 5;
  localparam int DP = 20;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [15:0]   trig_level = '0;
  logic          trig_rising = 1'b0;
  logic [AW-1:0] pre_len = '0;
  logic [AW-1:0] post_len = '0;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_word;
  logic          overflow;

  oscill_capture_writer #(
    .ADDR_W(AW),
    .DEPTH (DP),
    .FIFO_D(FD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .trig_level     (trig_level),
    .trig_rising    (trig_rising),
    .pre_len        (pre_len),
    .post_len       (post_len),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .trig_word      (trig_word),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] smp[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          wr0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      n_wr++;
      chk("byteen", 32'(avm_byteenable), 32'hF);
      if (sb.size() == 0) begin
        chk("unexp_wr", 32'(avm_address), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(avm_address), 32'(mon_e.a));
        chk("wr_data", avm_writedata, mon_e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    if (busy) chk("timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_start(input int pre, input int post,
                          input logic rise,
                          input logic [15:0] lvl);
    pre_len     = AW'(pre);
    post_len    = AW'(post);
    trig_rising = rise;
    trig_level  = lvl;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // drive smp[]; the first nexp pairs are expected at sequential addresses
  task automatic drive(input int nexp);
    for (int i = 0; i < smp.size(); i++) begin
      adc_data  = smp[i];
      adc_valid = 1'b1;
      if (i % 2 == 1 && i / 2 < nexp)
        sb.push_back('{a: AW'((i / 2) % DP),
                       d: {smp[i], smp[i-1]}});
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic req040();
    smp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60,
            16'd90, 16'd150, 16'd200, 16'd210, 16'd220,
            16'd230, 16'd240, 16'd250};
    wr0 = n_wr;
    do_start(2, 1, 1'b1, 16'd100);
    chk("busy_run", 32'(busy), 32'd1);
    drive(5);
    wait_idle(200);
    chk("r40_done", 32'(done), 32'd1);
    chk("r40_trig", 32'(trig_word), 32'd3);
    chk("r40_nwr", 32'(n_wr - wr0), 32'd5);
    chk("r40_sb", 32'(sb.size()), 32'd0);
    chk("r40_ovf", 32'(overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(avm_write), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_data", avm_writedata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    tick();

    // basic rising capture
    req040();

    // falling mode, pre_len = 0 arms at once
    smp = '{16'd500, 16'd400, 16'd450, 16'd600,
            16'd500, 16'd300, 16'd700, 16'd800};
    do_start(0, 0, 1'b0, 16'd500);
    chk("done_clr", 32'(done), 32'd0);
    drive(3);
    wait_idle(200);
    chk("fall_trig", 32'(trig_word), 32'd2);
    chk("fall_done", 32'(done), 32'd1);
    chk("fall_sb", 32'(sb.size()), 32'd0);

    // address wrap: trigger in word 23 -> slot 3
    smp.delete();
    for (int k = 0; k < 23; k++) begin
      smp.push_back(16'(2 * k));
      smp.push_back(16'(2 * k + 1));
    end
    smp.push_back(16'd10);
    smp.push_back(16'd2000);
    for (int k = 0; k < 4; k++) begin
      smp.push_back(16'(3000 + 2 * k));
      smp.push_back(16'(3001 + 2 * k));
    end
    do_start(DP - 1, 3, 1'b1, 16'd1000);
    drive(27);
    wait_idle(200);
    chk("wrap_trig", 32'(trig_word), 32'd3);
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_sb", 32'(sb.size()), 32'd0);

    // overflow under a 20-cycle stall
    avm_waitrequest = 1'b1;
    do_start(DP - 1, 0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      adc_data  = 16'(i + 1);
      adc_valid = 1'b1;
      if (i % 2 == 1 && i / 2 < FD)
        sb.push_back('{a: AW'(i / 2),
                       d: {16'(i + 1), 16'(i)}});
      tick();
      if (i == 7) chk("ovf_pre", 32'(overflow), 32'd0);
      if (i == 9) chk("ovf_set", 32'(overflow), 32'd1);
      if (i > 1 && i % 5 == 0) begin
        chk("stall_wr", 32'(avm_write), 32'd1);
        chk("stall_addr", 32'(avm_address), 32'd0);
        chk("stall_data", avm_writedata, 32'h0002_0001);
      end
    end
    adc_valid = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_sb", 32'(sb.size()), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(50);
    chk("ovf_done", 32'(done), 32'd0);
    chk("ovf_stick", 32'(overflow), 32'd1);

    // abort in POST with a stalled head
    avm_waitrequest = 1'b1;
    do_start(0, 10, 1'b1, 16'd100);
    chk("ovf_clr", 32'(overflow), 32'd0);
    sb.push_back('{a: AW'(0), d: {16'd200, 16'd10}});
    smp = '{16'd10, 16'd200, 16'd1, 16'd2, 16'd3, 16'd4};
    drive(0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    chk("abt_busy", 32'(busy), 32'd1);
    chk("abt_wr", 32'(avm_write), 32'd1);
    chk("abt_addr", 32'(avm_address), 32'd0);
    tick();
    avm_waitrequest = 1'b0;
    wait_idle(50);
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_busy0", 32'(busy), 32'd0);
    chk("abt_trig", 32'(trig_word), 32'd0);
    chk("abt_sb", 32'(sb.size()), 32'd0);
    tick();
    chk("abt_wr0", 32'(avm_write), 32'd0);

    // async reset mid-POST, then a normal capture
    smp = '{16'd10, 16'd200, 16'd5, 16'd6};
    do_start(0, 10, 1'b1, 16'd100);
    drive(1);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_wr", 32'(avm_write), 32'd0);
    chk("ar_addr", 32'(avm_address), 32'd0);
    chk("ar_data", avm_writedata, 32'd0);
    chk("ar_trig", 32'(trig_word), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_sb", 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    req040();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
